// File: rtl/core_config_pkg.sv
// Core-wide configuration constants and shared request types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_config_pkg;

    localparam int XLEN         = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int WB_SRC_COUNT = 4;

    // One result presented by an execution unit to the writeback arbiter.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // Index width for a round-robin pointer over n sources (at least 1 bit).
    function automatic int wb_ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
// Latency: zero cycles, pure combinational; pointer state lives in the parent.
// Backpressure: en=0 suppresses every grant.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx
);

    // Scan ptr, ptr+1, ... with wrap; the first set request wins.
    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter granting one register-file write per cycle; WB_BYPASS_EN adds a same-cycle forward port.
// Latency: grant combinational in T, rf/scoreboard write registered in T+1; one write per cycle back-to-back.
// Backpressure: wb_stall (or rst) blocks all grants; sources hold valid/addr/data until src_ready.
module writeback_arbiter
    import core_config_pkg::*;
#(
    parameter int N_SRC  = WB_SRC_COUNT,
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_ready,
    input  logic [N_SRC*ADDR_W-1:0] src_addr,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic                  wb_stall,
    output logic                  rf_we,
    output logic [ADDR_W-1:0]     rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  sb_write,
    output logic [ADDR_W-1:0]     sb_address,
    output logic                  busy
`ifdef WB_BYPASS_EN
    ,
    output logic                  byp_valid,
    output logic [ADDR_W-1:0]     byp_addr,
    output logic [DATA_W-1:0]     byp_data
`endif
);

    localparam int PTR_W = wb_ptr_w(N_SRC);

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  gnt_idx;
    logic [N_SRC-1:0]  gnt;
    logic              hs;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_live;

    // Grants are masked during reset so no source is consumed while state is being cleared.
    rr_arbiter #(.N(N_SRC), .PTR_W(PTR_W)) u_rr (
        .req     (src_valid),
        .ptr     (rr_ptr),
        .en      (~wb_stall & ~rst),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Mux out the winning source; writes to x0 are consumed but never land.
    always_comb begin
        src_ready = gnt;
        hs        = |gnt;
        sel_addr  = src_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        sel_data  = src_data[int'(gnt_idx)*DATA_W +: DATA_W];
        sel_live  = hs && (sel_addr != '0);
    end

    // Advance the round-robin pointer past the winner; hold when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (hs) begin
            rr_ptr <= (int'(gnt_idx) == N_SRC - 1) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    // Register the winning write; address/data hold when there is no handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= sel_live;
            if (hs) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
        end
    end

    // The scoreboard release rides on the same registered write.
    assign sb_write   = rf_we;
    assign sb_address = rf_waddr;
    assign busy       = (|src_valid) | rf_we;

`ifdef WB_BYPASS_EN
    // Forward the granted result to issue one cycle before the register file holds it.
    assign byp_valid = sel_live;
    assign byp_addr  = sel_addr;
    assign byp_data  = sel_data;
`endif

`ifndef SYNTHESIS
    a_onehot_gnt: assert property (@(posedge clk) disable iff (rst) $onehot0(src_ready));
    for (genvar i = 0; i < N_SRC; i++) begin : g_src_chk
        a_rdy_needs_vld: assert property (@(posedge clk) disable iff (rst)
            src_ready[i] |-> src_valid[i]);
        a_src_stable: assert property (@(posedge clk) disable iff (rst)
            (src_valid[i] && !src_ready[i]) |=> (src_valid[i]
                && $stable(src_addr[i*ADDR_W +: ADDR_W])
                && $stable(src_data[i*DATA_W +: DATA_W])));
    end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: grant order, x0, stall, same-destination and async reset.
// Latency: checks grants in T and registered writes in T+1.
// Backpressure: exercises wb_stall and reset masking of grants.
module tb_writeback_arbiter;
    import core_config_pkg::*;

    localparam int N  = 4;
    localparam int AW = REG_ADDR_W;
    localparam int DW = XLEN;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    src_valid = '0;
    logic [N-1:0]    src_ready;
    logic [N*AW-1:0] src_addr = '0;
    logic [N*DW-1:0] src_data = '0;
    logic            wb_stall = 1'b0;
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic            sb_write;
    logic [AW-1:0]   sb_address;
    logic            busy;
`ifdef WB_BYPASS_EN
    logic            byp_valid;
    logic [AW-1:0]   byp_addr;
    logic [DW-1:0]   byp_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    writeback_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .wb_stall   (wb_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .sb_write   (sb_write),
        .sb_address (sb_address),
        .busy       (busy)
`ifdef WB_BYPASS_EN
        ,
        .byp_valid  (byp_valid),
        .byp_addr   (byp_addr),
        .byp_data   (byp_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input wb_req_t r);
        src_valid[i]          = r.valid;
        src_addr[i*AW +: AW]  = r.addr;
        src_data[i*DW +: DW]  = r.data;
    endtask

    task automatic drop(input int i);
        src_valid[i] = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        // Reset state; requests present during reset must not be granted.
        for (int i = 0; i < N; i++) drive(i, '{1'b1, AW'(i + 1), DW'(32'hAAAA_0000 + i)});
        #3;
        check("rst_ready",   64'(src_ready),  64'h0);
        check("rst_busy",    64'(busy),       64'h1);
        check("rst_rf_we",   64'(rf_we),      64'h0);
        check("rst_waddr",   64'(rf_waddr),   64'h0);
        check("rst_wdata",   64'(rf_wdata),   64'h0);
        check("rst_sb_wr",   64'(sb_write),   64'h0);
        check("rst_sb_addr", 64'(sb_address), 64'h0);
        check("rst_ptr",     64'(dut.rr_ptr), 64'h0);
        src_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        check("idle_busy",   64'(busy),       64'h0);

        // Single request from source 1.
        drive(1, '{1'b1, 5'd7, 32'hDEAD_BEEF});
        #1;
        check("single_ready", 64'(src_ready), 64'b0010);
        tick();
        check("single_we",    64'(rf_we),      64'h1);
        check("single_waddr", 64'(rf_waddr),   64'd7);
        check("single_wdata", 64'(rf_wdata),   64'hDEAD_BEEF);
        check("single_sbwr",  64'(sb_write),   64'h1);
        check("single_sbadr", 64'(sb_address), 64'd7);
        drop(1);
        tick();
        check("single_we_off", 64'(rf_we),    64'h0);
        check("single_sb_off", 64'(sb_write), 64'h0);
        check("single_hold",   64'(rf_waddr), 64'd7);

        // All four continuously valid from pointer 0: 0,1,2,3,0 then drain.
        pulse_rst();
        tick();
        for (int i = 0; i < N; i++) drive(i, '{1'b1, AW'(i + 1), DW'(32'h1000_0000 + i)});
        #1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rr_gnt%0d", k), 64'(src_ready), 64'(4'b0001 << order[k]));
            tick();
            check($sformatf("rr_we%0d", k),   64'(rf_we),    64'h1);
            check($sformatf("rr_addr%0d", k), 64'(rf_waddr), 64'(order[k] + 1));
            check($sformatf("rr_data%0d", k), 64'(rf_wdata), 64'(32'h1000_0000 + order[k]));
            if (k >= 4) drop(order[k]);
            #1;
        end
        tick();
        check("rr_drained_we", 64'(rf_we),      64'h0);
        check("rr_drained_bz", 64'(busy),       64'h0);
        check("rr_ptr_wrap",   64'(dut.rr_ptr), 64'h0);

        // Write to x0 from source 2: consumed, no write, pointer advances.
        drive(2, '{1'b1, 5'd0, 32'h5555_5555});
        #1;
        check("x0_ready", 64'(src_ready), 64'b0100);
        check("x0_busy",  64'(busy),      64'h1);
        tick();
        check("x0_we",    64'(rf_we),      64'h0);
        check("x0_sbwr",  64'(sb_write),   64'h0);
        check("x0_ptr",   64'(dut.rr_ptr), 64'h3);
        drop(2);
        #1;
        check("x0_idle",  64'(busy),       64'h0);

        // Stall for three cycles with sources 0 and 3 waiting.
        pulse_rst();
        tick();
        wb_stall = 1'b1;
        drive(0, '{1'b1, 5'd5, 32'hA0A0_0000});
        drive(3, '{1'b1, 5'd6, 32'hA3A3_0003});
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall_ready%0d", c), 64'(src_ready),  64'h0);
            tick();
            check($sformatf("stall_we%0d", c),    64'(rf_we),      64'h0);
            check($sformatf("stall_ptr%0d", c),   64'(dut.rr_ptr), 64'h0);
        end
        wb_stall = 1'b0;
        #1;
        check("unstall_g0", 64'(src_ready), 64'b0001);
        tick();
        check("unstall_w0", 64'(rf_waddr), 64'd5);
        check("unstall_e0", 64'(rf_we),    64'h1);
        drop(0);
        #1;
        check("unstall_g3", 64'(src_ready), 64'b1000);
        tick();
        check("unstall_w3", 64'(rf_waddr), 64'd6);
        check("unstall_d3", 64'(rf_wdata), 64'hA3A3_0003);
        drop(3);

        // Sources 1 and 3 both target r12; writes land in grant order.
        drive(1, '{1'b1, 5'd12, 32'h1111_0001});
        drive(3, '{1'b1, 5'd12, 32'h3333_0003});
        #1;
        check("dup_g1", 64'(src_ready), 64'b0010);
        tick();
        check("dup_we1",   64'(rf_we),    64'h1);
        check("dup_addr1", 64'(rf_waddr), 64'd12);
        check("dup_data1", 64'(rf_wdata), 64'h1111_0001);
        drop(1);
        #1;
        check("dup_g3", 64'(src_ready), 64'b1000);
        tick();
        check("dup_we3",   64'(sb_write),   64'h1);
        check("dup_addr3", 64'(sb_address), 64'd12);
        check("dup_final", 64'(rf_wdata),   64'h3333_0003);
        drop(3);
        tick();
        check("dup_off", 64'(rf_we), 64'h0);

        // Reset while a write is pending: dropped immediately, pointer back to 0.
        drive(2, '{1'b1, 5'd9, 32'hC0C0_C0C0});
        #1;
        check("mid_g2", 64'(src_ready), 64'b0100);
        tick();
        check("mid_pend", 64'(rf_we), 64'h1);
        drop(2);
        #1;
        rst = 1'b1;
        drive(1, '{1'b1, 5'd3, 32'hD1D1_D1D1});
        drive(3, '{1'b1, 5'd4, 32'hD3D3_D3D3});
        #1;
        check("mid_rst_we",    64'(rf_we),     64'h0);
        check("mid_rst_sbwr",  64'(sb_write),  64'h0);
        check("mid_rst_waddr", 64'(rf_waddr),  64'h0);
        check("mid_rst_ready", 64'(src_ready), 64'h0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_g1",  64'(src_ready),  64'b0010);
        check("post_rst_ptr", 64'(dut.rr_ptr), 64'h0);
        tick();
        check("post_rst_addr", 64'(rf_waddr), 64'd3);
        drop(1);
        #1;
        check("post_rst_g3",  64'(src_ready), 64'b1000);
        tick();
        check("post_rst_a3",  64'(rf_waddr),  64'd4);
        drop(3);
        tick();
        check("final_busy",   64'(busy),      64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
